complete_queue: RTL and testbench
=================================

# complete_queue

Completion buffer between the functional-unit cluster and the common data bus (CDB). It accepts up to NUM_FU finished results per cycle, stores them in arrival order in a circular FIFO, and presents one result per cycle to the CDB consumer under a valid/ready handshake. Per-FU ready signals give the functional units backpressure, so a unit holds its result until it is accepted.

## Interface
- NUM_FU, 6: number of completion request lanes. Lane NUM_FU-1 has the highest priority; lane 5 is the branch unit.
- DEPTH, 8: number of FIFO entries. Must be a power of 2 and at least NUM_FU.
- XLEN, 32: result value width.
- PR_W, 6: physical-register index width.
- ROB_W, 5: ROB index width.
- clock  in  1  system clock. Rising edge is active.
- reset  in  1  synchronous reset, active-high.
- squash  in  1  synchronous flush of all queued entries (branch mispredict).
- fu_valid  in  NUM_FU  lane i has a finished result.
- fu_pr_idx  in  NUM_FU*PR_W  destination physical register; lane i occupies bits [i*PR_W +: PR_W].
- fu_value  in  NUM_FU*XLEN  result value, packed the same way.
- fu_rob_idx  in  NUM_FU*ROB_W  ROB index, packed the same way.
- fu_ready  out  NUM_FU  lane i is accepted this cycle if fu_valid[i] is also high. Combinational.
- cdb_valid  out  1  the head entry is valid.
- cdb_pr_idx  out  PR_W  head destination register.
- cdb_value  out  XLEN  head value.
- cdb_rob_idx  out  ROB_W  head ROB index.
- cdb_ready  in  1  the consumer takes the head this cycle.
- count  out  $clog2(DEPTH)+1  number of occupied entries (registered).

## Operation
- State: head and tail pointers, each $clog2(DEPTH) bits, which wrap modulo DEPTH. A count register, and DEPTH entry registers holding {pr_idx, value, rob_idx}.
- free = DEPTH - count. This is the registered value. A pop in the current cycle does not free a slot for the same cycle's pushes; there is no same-cycle slot reuse.
- Lane grant: fu_ready[i] = 1 when the number of asserted fu_valid[j] with j > i is less than free. For lanes with fu_valid low, fu_ready follows the same formula. fu_ready depends only on fu_valid and count, and never on cdb_ready.
- When squash=1, all fu_ready outputs are 0.
- Push order within a cycle: accepted lanes are written in descending lane index, starting at tail. The highest-index accepted lane lands at tail, the next at tail+1, and so on, modulo DEPTH.
- tail advances by the number of accepted lanes (npush).
- Pop: pop = cdb_valid & cdb_ready. When pop is high, head advances by 1.
- count_next = count + npush - pop.
- Output drive:
  - cdb_valid = (count != 0).
  - The cdb_* fields come from entry[head] when count is nonzero; otherwise they are all 0.
- Push-to-CDB behaviour:
  - There is no bypass. A pushed entry is visible on cdb_* no earlier than the next cycle.
  - Entries leave in push order.
- Squash: at the clock edge, head, tail and count are cleared to 0, and same-cycle pushes and pops are discarded.
- Reset:
  - head, tail and count clear to 0, and entries clear to 0.
  - After reset, cdb_valid=0 and cdb_pr_idx, cdb_value and cdb_rob_idx are 0.
  - fu_ready is all-ones whenever count=0 and squash=0, provided NUM_FU <= DEPTH.
- Reset takes priority over squash, and squash takes priority over push and pop.
- Invariant: count never exceeds DEPTH. Overflow is impossible by construction, and the bench asserts this.

## Timing
- Latency: 1 cycle. An accepted push at edge N makes the entry visible on cdb_* after edge N, provided the queue ahead of it is empty.
- Throughput:
  - Pushes: up to NUM_FU per cycle.
  - Pops: 1 per cycle.
  - Sustained full occupancy with cdb_ready=1 admits 1 push per cycle, which lands one cycle after the slot is freed.
- Full, count=DEPTH: fu_ready is all-zero and cdb_valid=1. A pop frees one slot, visible on fu_ready the next cycle.
- Empty, count=0: cdb_valid=0. cdb_ready is ignored and no pop occurs.
- Simultaneous push and pop at count=DEPTH-1 with 2 requesters: only the highest lane is accepted, and count stays at DEPTH-1.
- Pointer wrap: with tail=DEPTH-1 and 3 pushes, entries land at indices 7, 0 and 1 (DEPTH=8), and tail becomes 2.
- fu_ready is combinational from the inputs. The cdb_* outputs and count are registered state or decode of registered state, with no input-to-output path.

## Test plan
- Reset, then idle: count=0, cdb_valid=0, cdb_* all 0, fu_ready=6'b111111.
- Single push, lane 2, pr=6'd9, value=32'hDEAD_BEEF, rob=5'd3, cdb_ready=1: the next cycle shows cdb_valid=1 with those exact fields; the cycle after that shows cdb_valid=0 and count=0.
- Six lanes valid at once with cdb_ready=0: count goes 0→6. Popping then yields lanes in order 5,4,3,2,1,0, one per cycle.
- Fill to 8 with cdb_ready=0, then assert all fu_valid:
  - fu_ready=0, and the held lanes are not enqueued.
  - Raise cdb_ready for one cycle: count goes 8→7, and on the next cycle fu_ready=6'b100000.
- Wrap-around: push and pop traffic until head=6 and tail=6, then push 4 lanes: entries land at 6, 7, 0 and 1, and pop order matches push order.
- Squash with count=5 plus 3 same-cycle pushes: the next cycle shows count=0 and cdb_valid=0, none of the 3 pushes appears, and fu_ready=0 during the squash cycle.

Source files
------------

// File: rtl/complete_queue_if.sv
// Completion-queue bus: FU result lanes in, CDB result out, plus occupancy.
//   fu_valid/fu_pr_idx/fu_value/fu_rob_idx : packed per-lane results (lane i at [i*W +: W])
//   fu_ready                               : per-lane grant (combinational)
//   cdb_valid/cdb_pr_idx/cdb_value/cdb_rob_idx, cdb_ready : head-of-queue handshake
//   count                                  : registered occupancy
// master = FU cluster / CDB consumer side, slave = the queue.
interface complete_queue_if #(
  parameter int unsigned NUM_FU = 6,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PR_W   = 6,
  parameter int unsigned ROB_W  = 5
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_FU-1:0]       fu_valid;
  logic [NUM_FU*PR_W-1:0]  fu_pr_idx;
  logic [NUM_FU*XLEN-1:0]  fu_value;
  logic [NUM_FU*ROB_W-1:0] fu_rob_idx;
  logic [NUM_FU-1:0]       fu_ready;
  logic                    cdb_valid;
  logic [PR_W-1:0]         cdb_pr_idx;
  logic [XLEN-1:0]         cdb_value;
  logic [ROB_W-1:0]        cdb_rob_idx;
  logic                    cdb_ready;
  logic [CNT_W-1:0]        count;

  modport master (
    output fu_valid, fu_pr_idx, fu_value, fu_rob_idx, cdb_ready,
    input  fu_ready, cdb_valid, cdb_pr_idx, cdb_value, cdb_rob_idx, count
  );

  modport slave (
    input  fu_valid, fu_pr_idx, fu_value, fu_rob_idx, cdb_ready,
    output fu_ready, cdb_valid, cdb_pr_idx, cdb_value, cdb_rob_idx, count
  );
endinterface

// File: rtl/complete_queue.sv
// Completion buffer between the FU cluster and the CDB. Accepts up to NUM_FU
// results per cycle (highest lane first), stores them in a circular FIFO and
// presents one result per cycle to the CDB under valid/ready.
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset
//   squash : synchronous flush of all queued entries
//   bus    : complete_queue_if slave (FU lanes in, CDB out, count)
module complete_queue #(
  parameter int unsigned NUM_FU = 6,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PR_W   = 6,
  parameter int unsigned ROB_W  = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            squash,
  complete_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PR_W-1:0]  pr_idx;
    logic [XLEN-1:0]  value;
    logic [ROB_W-1:0] rob_idx;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [CNT_W-1:0]  free_c;
  logic [CNT_W-1:0]  nhigher;
  logic [CNT_W-1:0]  npush;
  logic [NUM_FU-1:0] ready_c;
  logic [PTR_W-1:0]  wr_idx;
  logic              pop;
  entry_t            head_ent;

  // Lane grant and slot write. Lanes are scanned from the top, so the running
  // count of higher valid lanes is both the grant test and the write offset:
  // every lane above an accepted lane is itself accepted.
  always_comb begin
    free_c  = CNT_W'(DEPTH) - count_q;
    nhigher = '0;
    npush   = '0;
    ready_c = '0;
    wr_idx  = '0;
    for (int k = 0; k < int'(DEPTH); k++) mem_d[k] = mem_q[k];
    for (int i = int'(NUM_FU) - 1; i >= 0; i--) begin
      ready_c[i] = !squash && (nhigher < free_c);
      if (bus.fu_valid[i]) begin
        if (ready_c[i]) begin
          wr_idx        = tail_q + PTR_W'(nhigher);
          mem_d[wr_idx] = '{pr_idx:  bus.fu_pr_idx[i*PR_W +: PR_W],
                            value:   bus.fu_value[i*XLEN +: XLEN],
                            rob_idx: bus.fu_rob_idx[i*ROB_W +: ROB_W]};
          npush         = npush + CNT_W'(1);
        end
        nhigher = nhigher + CNT_W'(1);
      end
    end
  end

  // Pointer and occupancy update; squash discards this cycle's traffic.
  always_comb begin
    pop     = (count_q != '0) && bus.cdb_ready;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop);
      tail_d  = tail_q + PTR_W'(npush);
      count_d = count_q + npush - CNT_W'(pop);
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) mem_q[k] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int k = 0; k < int'(DEPTH); k++) mem_q[k] <= mem_d[k];
    end
  end

  // Head decode; fields read as zero when the queue is empty.
  always_comb begin
    head_ent = '0;
    if (count_q != '0) head_ent = mem_q[head_q];
  end

  assign bus.fu_ready    = ready_c;
  assign bus.cdb_valid   = (count_q != '0);
  assign bus.cdb_pr_idx  = head_ent.pr_idx;
  assign bus.cdb_value   = head_ent.value;
  assign bus.cdb_rob_idx = head_ent.rob_idx;
  assign bus.count       = count_q;
endmodule

// File: tb/tb_complete_queue.sv
// Self-checking bench for complete_queue: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
module tb_complete_queue;
  localparam int unsigned NUM_FU = 6;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned PR_W   = 6;
  localparam int unsigned ROB_W  = 5;
  localparam int unsigned CNT_W  = 4;

  logic clock = 1'b0;
  logic reset;
  logic squash;
  always #5 clock = ~clock;

  complete_queue_if #(.NUM_FU(NUM_FU), .DEPTH(DEPTH), .XLEN(XLEN), .PR_W(PR_W), .ROB_W(ROB_W)) bus();

  complete_queue #(.NUM_FU(NUM_FU), .DEPTH(DEPTH), .XLEN(XLEN), .PR_W(PR_W), .ROB_W(ROB_W)) dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [PR_W-1:0]  pr;
    logic [XLEN-1:0]  val;
    logic [ROB_W-1:0] rob;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Lane i may enter when fewer than 'free' valid lanes sit above it.
  function automatic logic [NUM_FU-1:0] model_ready(input logic [NUM_FU-1:0] v, input int occ, input logic sq);
    logic [NUM_FU-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NUM_FU); i++) begin
      int above;
      above = 0;
      for (int j = i + 1; j < int'(NUM_FU); j++) if (v[j]) above++;
      r[i] = !sq && (above < int'(DEPTH) - occ);
    end
    return r;
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.pr  = PR_W'($urandom);
    e.val = $urandom;
    e.rob = ROB_W'($urandom);
    return e;
  endfunction

  task automatic set_lane(input int i, input ent_t e);
    bus.fu_pr_idx[i*PR_W +: PR_W]    = e.pr;
    bus.fu_value[i*XLEN +: XLEN]     = e.val;
    bus.fu_rob_idx[i*ROB_W +: ROB_W] = e.rob;
  endtask

  function automatic ent_t lane_ent(input int i);
    ent_t e;
    e.pr  = bus.fu_pr_idx[i*PR_W +: PR_W];
    e.val = bus.fu_value[i*XLEN +: XLEN];
    e.rob = bus.fu_rob_idx[i*ROB_W +: ROB_W];
    return e;
  endfunction

  // Advance one clock and update the model from the inputs held across the edge.
  task automatic step();
    logic [NUM_FU-1:0] acc;
    bit                pop;
    acc = bus.fu_valid & model_ready(bus.fu_valid, q.size(), squash);
    pop = (q.size() != 0) && bus.cdb_ready;
    @(posedge clock);
    if (reset || squash) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      for (int i = int'(NUM_FU) - 1; i >= 0; i--) if (acc[i]) q.push_back(lane_ent(i));
    end
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    squash        = 1'b0;
    bus.fu_valid  = '0;
    bus.cdb_ready = 1'b0;
    step();
    reset = 1'b0;
    #1;
  endtask

  // Occupancy must never exceed DEPTH.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      checks++;
      if (bus.count > CNT_W'(DEPTH)) begin
        errors++;
        $display("FAIL overflow: count=%0d limit=%0d", bus.count, DEPTH);
      end
    end
  end

  task automatic test_reset();
    reset         = 1'b1;
    squash        = 1'b0;
    bus.fu_valid  = '0;
    bus.fu_pr_idx = '0;
    bus.fu_value  = '0;
    bus.fu_rob_idx = '0;
    bus.cdb_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", bus.count); end
    checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", bus.cdb_valid); end
    checks++; if ({bus.cdb_pr_idx, bus.cdb_value, bus.cdb_rob_idx} !== '0) begin
      errors++; $display("FAIL reset_fields: got %h/%h/%h exp 0", bus.cdb_pr_idx, bus.cdb_value, bus.cdb_rob_idx);
    end
    checks++; if (bus.fu_ready !== 6'b111111) begin errors++; $display("FAIL reset_ready: got %b exp 111111", bus.fu_ready); end
  endtask

  task automatic test_single_push();
    ent_t e;
    do_reset();
    e.pr = 6'd9; e.val = 32'hDEAD_BEEF; e.rob = 5'd3;
    set_lane(2, e);
    bus.fu_valid  = 6'b000100;
    bus.cdb_ready = 1'b1;
    #1;
    checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b exp 0", bus.cdb_valid); end
    step();
    bus.fu_valid = '0;
    #1;
    checks++; if (bus.cdb_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", bus.cdb_valid); end
    checks++; if (bus.cdb_pr_idx !== 6'd9 || bus.cdb_value !== 32'hDEAD_BEEF || bus.cdb_rob_idx !== 5'd3) begin
      errors++; $display("FAIL single_fields: got %0d/%h/%0d exp 9/deadbeef/3", bus.cdb_pr_idx, bus.cdb_value, bus.cdb_rob_idx);
    end
    step();
    checks++; if (bus.cdb_valid !== 1'b0 || bus.count !== 4'd0) begin
      errors++; $display("FAIL single_drain: valid=%b count=%0d exp 0/0", bus.cdb_valid, bus.count);
    end
    bus.cdb_ready = 1'b0;
  endtask

  task automatic test_six_lanes();
    ent_t exp_e [NUM_FU];
    do_reset();
    for (int i = 0; i < int'(NUM_FU); i++) begin exp_e[i] = rand_ent(); set_lane(i, exp_e[i]); end
    bus.fu_valid  = '1;
    bus.cdb_ready = 1'b0;
    #1;
    checks++; if (bus.fu_ready !== 6'b111111) begin errors++; $display("FAIL six_ready: got %b exp 111111", bus.fu_ready); end
    step();
    bus.fu_valid = '0;
    #1;
    checks++; if (bus.count !== 4'd6) begin errors++; $display("FAIL six_count: got %0d exp 6", bus.count); end
    bus.cdb_ready = 1'b1;
    for (int k = 0; k < int'(NUM_FU); k++) begin
      int ln;
      ln = int'(NUM_FU) - 1 - k;
      checks++;
      if (bus.cdb_valid !== 1'b1 || bus.cdb_pr_idx !== exp_e[ln].pr || bus.cdb_value !== exp_e[ln].val ||
          bus.cdb_rob_idx !== exp_e[ln].rob) begin
        errors++; $display("FAIL six_order[%0d]: got v=%b %h exp lane %0d %h", k, bus.cdb_valid, bus.cdb_value, ln, exp_e[ln].val);
      end
      step();
    end
    checks++; if (bus.count !== 4'd0 || bus.cdb_valid !== 1'b0) begin
      errors++; $display("FAIL six_empty: count=%0d valid=%b exp 0/0", bus.count, bus.cdb_valid);
    end
    bus.cdb_ready = 1'b0;
  endtask

  task automatic test_full_backpressure();
    do_reset();
    bus.cdb_ready = 1'b0;
    for (int i = 0; i < int'(NUM_FU); i++) set_lane(i, rand_ent());
    bus.fu_valid = '1;
    step();
    for (int i = 0; i < int'(NUM_FU); i++) set_lane(i, rand_ent());
    bus.fu_valid = 6'b000011;
    #1;
    checks++; if (bus.fu_ready !== 6'b111111) begin errors++; $display("FAIL full_two_free: got %b exp 111111", bus.fu_ready); end
    step();
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d exp 8", bus.count); end
    bus.fu_valid = '1;
    #1;
    checks++; if (bus.fu_ready !== 6'b000000 || bus.cdb_valid !== 1'b1) begin
      errors++; $display("FAIL full_ready: ready=%b valid=%b exp 000000/1", bus.fu_ready, bus.cdb_valid);
    end
    step();
    checks++; if (bus.count !== 4'd8 || bus.cdb_value !== q[0].val) begin
      errors++; $display("FAIL full_held: count=%0d head=%h exp 8/%h", bus.count, bus.cdb_value, q[0].val);
    end
    bus.cdb_ready = 1'b1;
    #1;
    checks++; if (bus.fu_ready !== 6'b000000) begin errors++; $display("FAIL full_pop_no_reuse: got %b exp 000000", bus.fu_ready); end
    step();
    bus.cdb_ready = 1'b0;
    #1;
    checks++; if (bus.count !== 4'd7 || bus.fu_ready !== 6'b100000) begin
      errors++; $display("FAIL full_after_pop: count=%0d ready=%b exp 7/100000", bus.count, bus.fu_ready);
    end
    bus.cdb_ready = 1'b1;
    step();
    checks++; if (bus.count !== 4'd7) begin errors++; $display("FAIL full_push_pop: got %0d exp 7", bus.count); end
    bus.fu_valid  = '0;
    bus.cdb_ready = 1'b0;
  endtask

  task automatic test_wrap();
    ent_t exp_e [4];
    int   slot [4];
    slot[0] = 6; slot[1] = 7; slot[2] = 0; slot[3] = 1;
    do_reset();
    for (int i = 0; i < int'(NUM_FU); i++) set_lane(i, rand_ent());
    bus.fu_valid = '1;
    step();
    bus.fu_valid  = '0;
    bus.cdb_ready = 1'b1;
    repeat (6) step();
    bus.cdb_ready = 1'b0;
    #1;
    checks++; if (dut.head_q !== 3'd6 || dut.tail_q !== 3'd6 || bus.count !== 4'd0) begin
      errors++; $display("FAIL wrap_setup: head=%0d tail=%0d count=%0d exp 6/6/0", dut.head_q, dut.tail_q, bus.count);
    end
    for (int k = 0; k < 4; k++) begin exp_e[k] = rand_ent(); set_lane(3 - k, exp_e[k]); end
    bus.fu_valid = 6'b001111;
    step();
    bus.fu_valid = '0;
    #1;
    checks++; if (dut.tail_q !== 3'd2 || bus.count !== 4'd4) begin
      errors++; $display("FAIL wrap_tail: tail=%0d count=%0d exp 2/4", dut.tail_q, bus.count);
    end
    for (int k = 0; k < 4; k++) begin
      int s;
      s = slot[k];
      checks++;
      if (dut.mem_q[s].value !== exp_e[k].val || dut.mem_q[s].pr_idx !== exp_e[k].pr) begin
        errors++; $display("FAIL wrap_slot[%0d]: got %h exp %h", s, dut.mem_q[s].value, exp_e[k].val);
      end
    end
    bus.cdb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.cdb_value !== exp_e[k].val || bus.cdb_rob_idx !== exp_e[k].rob) begin
        errors++; $display("FAIL wrap_order[%0d]: got %h exp %h", k, bus.cdb_value, exp_e[k].val);
      end
      step();
    end
    bus.cdb_ready = 1'b0;
  endtask

  task automatic test_squash();
    do_reset();
    for (int i = 0; i < int'(NUM_FU); i++) set_lane(i, rand_ent());
    bus.fu_valid = 6'b011111;
    step();
    checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL squash_fill: got %0d exp 5", bus.count); end
    for (int i = 0; i < int'(NUM_FU); i++) set_lane(i, rand_ent());
    bus.fu_valid  = 6'b000111;
    bus.cdb_ready = 1'b1;
    squash        = 1'b1;
    #1;
    checks++; if (bus.fu_ready !== 6'b000000) begin errors++; $display("FAIL squash_ready: got %b exp 000000", bus.fu_ready); end
    step();
    squash        = 1'b0;
    bus.fu_valid  = '0;
    bus.cdb_ready = 1'b0;
    #1;
    checks++; if (bus.count !== 4'd0 || bus.cdb_valid !== 1'b0 || bus.cdb_value !== 32'd0) begin
      errors++; $display("FAIL squash_clear: count=%0d valid=%b value=%h exp 0/0/0", bus.count, bus.cdb_valid, bus.cdb_value);
    end
    step();
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL squash_no_push: got %0d exp 0", bus.count); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [NUM_FU-1:0] exp_r;
      for (int i = 0; i < int'(NUM_FU); i++) set_lane(i, rand_ent());
      if (c < 300) begin
        bus.fu_valid  = NUM_FU'($urandom);
        bus.cdb_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.fu_valid  = NUM_FU'($urandom & $urandom & $urandom);
        bus.cdb_ready = ($urandom_range(0, 9) < 8);
      end
      squash = ($urandom_range(0, 24) == 0);
      #1;
      exp_r = model_ready(bus.fu_valid, q.size(), squash);
      checks++; if (bus.fu_ready !== exp_r) begin
        errors++; $display("FAIL rand_ready@%0d: got %b exp %b", c, bus.fu_ready, exp_r);
      end
      checks++; if (bus.count !== CNT_W'(q.size()) || bus.cdb_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL rand_count@%0d: count=%0d valid=%b exp %0d", c, bus.count, bus.cdb_valid, q.size());
      end
      checks++;
      if (q.size() != 0) begin
        if (bus.cdb_pr_idx !== q[0].pr || bus.cdb_value !== q[0].val || bus.cdb_rob_idx !== q[0].rob) begin
          errors++; $display("FAIL rand_head@%0d: got %h/%h/%h exp %h/%h/%h", c, bus.cdb_pr_idx, bus.cdb_value,
                             bus.cdb_rob_idx, q[0].pr, q[0].val, q[0].rob);
        end
      end else if ({bus.cdb_pr_idx, bus.cdb_value, bus.cdb_rob_idx} !== '0) begin
        errors++; $display("FAIL rand_empty_fields@%0d: got %h/%h/%h exp 0", c, bus.cdb_pr_idx, bus.cdb_value, bus.cdb_rob_idx);
      end
      step();
    end
    squash        = 1'b0;
    bus.fu_valid  = '0;
    bus.cdb_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_six_lanes();
    test_full_backpressure();
    test_wrap();
    test_squash();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
